// File: rtl/usb_wr_sched_pkg.sv
// Shared types and constants for the FX3 slave-FIFO write scheduler.
package usb_wr_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_BURST,
    ST_PKTEND,
    ST_GAP
  } state_t;

  localparam logic [1:0]  SLADDR_DP2 = 2'd2;
  localparam logic [1:0]  SLADDR_DP3 = 2'd3;
  localparam int unsigned GAP_CYCLES = 3;

  function automatic logic [1:0] sladdr_of(input logic ch);
    return ch ? SLADDR_DP3 : SLADDR_DP2;
  endfunction

endpackage

// File: rtl/usb_wr_sched_if.sv
// FX3 slave-FIFO write-side bus: socket flags in, strobes/address/data out.
interface usb_wr_sched_if;
  logic        FLAGA_i;
  logic        FLAGB_i;
  logic [1:0]  SLADDR_o;
  logic        SLCSn_o;
  logic        SLWRn_o;
  logic        PKTENDn_o;
  logic [31:0] DQ_o;

  modport master (
    input  FLAGA_i, FLAGB_i,
    output SLADDR_o, SLCSn_o, SLWRn_o, PKTENDn_o, DQ_o
  );

  modport slave (
    output FLAGA_i, FLAGB_i,
    input  SLADDR_o, SLCSn_o, SLWRn_o, PKTENDn_o, DQ_o
  );
endinterface

// File: rtl/usb_rr_arb.sv
// Two-requester round-robin arbiter; the requester not served last wins a tie.
module usb_rr_arb (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_ch,
  output logic       gnt
);

  logic last;

  // Reset to channel 1 so that channel 0 (dp2) is served first.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)  last <= 1'b1;
    else if (upd) last <= upd_ch;
  end

  always_comb begin
    gnt = req[1];
    if (&req) gnt = ~last;
  end

endmodule

// File: rtl/usb_wr_sched.sv
// Round-robin FX3 write scheduler for two FWFT FIFOs (dp2 -> socket 2, dp3 -> socket 3).
// Define USB_WR_SCHED_PKTEND_EN to commit short packets with PKTENDn after IDLE_TMO stall cycles.
module usb_wr_sched import usb_wr_sched_pkg::*; #(
  parameter int unsigned BURST_WORDS = 256,
  parameter int unsigned IDLE_TMO    = 64
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  input  logic        dp2_epty_i,
  input  logic        dp3_epty_i,
  input  logic [31:0] dp2_dt_i,
  input  logic [31:0] dp3_dt_i,
  output logic        dp2_rd_o,
  output logic        dp3_rd_o,
  output logic        dp2_done_o,
  output logic        dp3_done_o,
  output logic        busy_o,
  usb_wr_sched_if.master fx3
);

  localparam int unsigned    CW       = $clog2(BURST_WORDS + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(BURST_WORDS);

  if (BURST_WORDS < 2 || BURST_WORDS > 1024) begin : g_bad_burst
    $error("usb_wr_sched: BURST_WORDS out of range 2..1024");
  end
  if (IDLE_TMO < 1 || IDLE_TMO > 255) begin : g_bad_tmo
    $error("usb_wr_sched: IDLE_TMO out of range 1..255");
  end

  state_t        state;
  logic          ch;        // granted channel: 0 = dp2, 1 = dp3
  logic [CW-1:0] cnt;
  logic [1:0]    gap_cnt;
  logic [1:0]    req;
  logic          gnt;
  logic          arb_upd;
  logic          cur_epty;
  logic          cur_flag;
  logic [31:0]   cur_dt;
  logic          wr_ok;

`ifdef USB_WR_SCHED_PKTEND_EN
  localparam logic [7:0] TMO = 8'(IDLE_TMO);
  logic [7:0] stall;
`else
  assign fx3.PKTENDn_o = 1'b1;
`endif

  assign req     = {~dp3_epty_i & fx3.FLAGB_i, ~dp2_epty_i & fx3.FLAGA_i};
  assign arb_upd = (state == ST_GAP) && (gap_cnt == 2'(GAP_CYCLES - 1));
  assign busy_o  = (state != ST_IDLE);

  usb_rr_arb u_arb (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .req    (req),
    .upd    (arb_upd),
    .upd_ch (ch),
    .gnt    (gnt)
  );

  always_comb begin
    cur_epty = ch ? dp3_epty_i : dp2_epty_i;
    cur_flag = ch ? fx3.FLAGB_i : fx3.FLAGA_i;
    cur_dt   = ch ? dp3_dt_i : dp2_dt_i;
    wr_ok    = (state == ST_BURST) && !cur_epty && cur_flag && (cnt < CNT_FULL);
  end

  // FWFT pop and data capture share one edge, so SLWRn_o and DQ_o line up a cycle later.
  assign dp2_rd_o = wr_ok & ~ch;
  assign dp3_rd_o = wr_ok & ch;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= ST_IDLE;
      ch           <= 1'b0;
      cnt          <= '0;
      gap_cnt      <= '0;
      dp2_done_o   <= 1'b0;
      dp3_done_o   <= 1'b0;
      fx3.SLADDR_o <= SLADDR_DP2;
      fx3.SLCSn_o  <= 1'b1;
      fx3.SLWRn_o  <= 1'b1;
      fx3.DQ_o     <= '0;
`ifdef USB_WR_SCHED_PKTEND_EN
      fx3.PKTENDn_o <= 1'b1;
      stall         <= '0;
`endif
    end else begin
      dp2_done_o  <= 1'b0;
      dp3_done_o  <= 1'b0;
      fx3.SLWRn_o <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (en_i && (|req)) begin
            ch           <= gnt;
            fx3.SLADDR_o <= sladdr_of(gnt);
            fx3.SLCSn_o  <= 1'b0;
            state        <= ST_SEL;
          end
        end
        ST_SEL: begin
          cnt   <= '0;
`ifdef USB_WR_SCHED_PKTEND_EN
          stall <= '0;
`endif
          state <= ST_BURST;
        end
        ST_BURST: begin
          if (wr_ok) begin
            fx3.DQ_o    <= cur_dt;
            fx3.SLWRn_o <= 1'b0;
            cnt         <= cnt + 1'b1;
`ifdef USB_WR_SCHED_PKTEND_EN
            stall       <= '0;
`endif
          end else if (cnt == CNT_FULL) begin
            // Last word already strobed; the FX3 auto-commits the full packet.
            fx3.SLCSn_o <= 1'b1;
            dp2_done_o  <= ~ch;
            dp3_done_o  <= ch;
            gap_cnt     <= '0;
            state       <= ST_GAP;
          end
`ifdef USB_WR_SCHED_PKTEND_EN
          else if (cnt != '0 && stall == TMO) begin
            fx3.PKTENDn_o <= 1'b0;
            dp2_done_o    <= ~ch;
            dp3_done_o    <= ch;
            state         <= ST_PKTEND;
          end else if (stall != TMO) begin
            stall <= stall + 1'b1;
          end
`endif
        end
`ifdef USB_WR_SCHED_PKTEND_EN
        ST_PKTEND: begin
          fx3.PKTENDn_o <= 1'b1;
          fx3.SLCSn_o   <= 1'b1;
          gap_cnt       <= '0;
          state         <= ST_GAP;
        end
`endif
        ST_GAP: begin
          if (gap_cnt == 2'(GAP_CYCLES - 1)) state <= ST_IDLE;
          else                               gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_wr_sched.sv
// Scoreboard bench for usb_wr_sched: FIFO models, packet-level reference model, decoupled monitor.
module tb_usb_wr_sched;

  localparam int BW  = 256;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        dp2_epty = 1'b1, dp3_epty = 1'b1;
  logic [31:0] dp2_dt = '0, dp3_dt = '0;
  logic        dp2_rd, dp3_rd, dp2_done, dp3_done, busy;

  usb_wr_sched_if fx3 ();

  usb_wr_sched #(.BURST_WORDS(BW), .IDLE_TMO(TMO)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .en_i       (en),
    .dp2_epty_i (dp2_epty),
    .dp3_epty_i (dp3_epty),
    .dp2_dt_i   (dp2_dt),
    .dp3_dt_i   (dp3_dt),
    .dp2_rd_o   (dp2_rd),
    .dp3_rd_o   (dp3_rd),
    .dp2_done_o (dp2_done),
    .dp3_done_o (dp3_done),
    .busy_o     (busy),
    .fx3        (fx3)
  );

  always #5 clk = ~clk;

  // FIFO contents (bench-owned), model copies and scoreboard queues
  logic [31:0] q2[$], q3[$], m2[$], m3[$];
  logic [33:0] exp_q[$];
  int          exp_done[$];
  bit          m_last = 1'b1;

  int n_chk = 0, n_err = 0;
  int pop2 = 0, pop3 = 0, both_err = 0, under_err = 0;
  int wr_cnt = 0, done_cnt = 0, pktend_cnt = 0;
  int hi_run = 0, max_stall = 0, last_stall = 0, cs_hi = 0, last_cs_gap = 0, pkt_words = 0;
  logic [31:0] tmp2, tmp3;

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic load(input bit ch, input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (ch) begin q3.push_back(w); m3.push_back(w); end
      else    begin q2.push_back(w); m2.push_back(w); end
    end
  endtask

  // Packet-level model: round-robin over non-empty channels, up to BW words per packet.
  task automatic sched(input int npkts);
    for (int p = 0; p < npkts; p++) begin
      bit pick;
      int take;
      logic [1:0] a;
      logic [31:0] w;
      if (m2.size() > 0 && m3.size() > 0) pick = !m_last;
      else if (m3.size() > 0)             pick = 1'b1;
      else if (m2.size() > 0)             pick = 1'b0;
      else                                return;
      a = pick ? 2'd3 : 2'd2;
      take = 0;
      while (take < BW && (pick ? m3.size() : m2.size()) > 0) begin
        w = pick ? m3.pop_front() : m2.pop_front();
        exp_q.push_back({a, w});
        take++;
      end
`ifdef USB_WR_SCHED_PKTEND_EN
      exp_done.push_back((pick ? 2 : 1) * 4096 + take);
`else
      if (take == BW) exp_done.push_back((pick ? 2 : 1) * 4096 + take);
`endif
      m_last = pick;
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int c = 0;
    while (done_cnt < target && c < budget) begin @(negedge clk); c++; end
    chk(name, longint'(done_cnt >= target), 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c = 0;
    while (busy !== 1'b0 && c < budget) begin @(negedge clk); c++; end
    chk(name, longint'(busy), 0);
  endtask

  task automatic wait_pop2(input int target, input int budget, input string name);
    int c = 0;
    while (pop2 < target && c < budget) begin @(negedge clk); c++; end
    chk(name, longint'(pop2 >= target), 1);
  endtask

  // FWFT FIFO models: pop on rd at the active edge
  always @(posedge clk) begin
    if (dp2_rd && dp3_rd) both_err++;
    if (dp2_rd) begin
      if (q2.size() == 0) under_err++; else tmp2 = q2.pop_front();
      pop2++;
    end
    if (dp3_rd) begin
      if (q3.size() == 0) under_err++; else tmp3 = q3.pop_front();
      pop3++;
    end
  end

  always @(negedge clk) begin
    dp2_epty = (q2.size() == 0);
    dp2_dt   = (q2.size() != 0) ? q2[0] : '0;
    dp3_epty = (q3.size() == 0);
    dp3_dt   = (q3.size() != 0) ? q3[0] : '0;
  end

  // Monitor: compares every write and done pulse against the scoreboard queues
  always @(negedge clk) begin
    if (rstn) begin
      if (dp2_done || dp3_done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_done: got ch %0b words %0d, expected none", {dp3_done, dp2_done}, pkt_words);
        end else
          chk("done_ch_words", longint'({dp3_done, dp2_done}) * 4096 + pkt_words, exp_done.pop_front());
      end
      if (!fx3.SLWRn_o) begin
        chk("cs_during_wr", longint'(fx3.SLCSn_o), 0);
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected none", fx3.SLADDR_o, fx3.DQ_o);
        end else
          chk("wr_addr_data", longint'({fx3.SLADDR_o, fx3.DQ_o}), longint'(exp_q.pop_front()));
        wr_cnt++;
        if (pkt_words > 0 && hi_run > max_stall) max_stall = hi_run;
        pkt_words++;
        hi_run = 0;
      end else if (!fx3.SLCSn_o && fx3.PKTENDn_o) begin
        hi_run++;
      end
      if (!fx3.PKTENDn_o) begin
        pktend_cnt++;
        last_stall = hi_run;
        chk("pktend_wr_high", longint'(fx3.SLWRn_o), 1);
      end
      if (fx3.SLCSn_o) begin
        cs_hi++; pkt_words = 0; hi_run = 0;
      end else if (cs_hi > 0) begin
        last_cs_gap = cs_hi; cs_hi = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    int d, p2, pk, w0;
    fx3.FLAGA_i = 1'b1;
    fx3.FLAGB_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_slcs",   longint'(fx3.SLCSn_o), 1);
    chk("rst_slwr",   longint'(fx3.SLWRn_o), 1);
    chk("rst_pktend", longint'(fx3.PKTENDn_o), 1);
    chk("rst_sladdr", longint'(fx3.SLADDR_o), 2);
    chk("rst_dq",     longint'(fx3.DQ_o), 0);
    chk("rst_busy",   longint'(busy), 0);
    chk("rst_rd",     longint'({dp2_rd, dp3_rd}), 0);
    chk("rst_done",   longint'({dp2_done, dp3_done}), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Both channels loaded: alternating full packets; en dropped inside the 4th
    load(0, 600); load(1, 600); sched(4); en = 1'b1;
    w0 = wr_cnt;
    while (wr_cnt < w0 + 3 * BW + 10 && wr_cnt < w0 + 4 * BW) @(negedge clk);
    en = 1'b0;
    wait_done(4, 1500, "t2_four_packets");
    wait_idle(50, "t2_idle");
    repeat (20) @(negedge clk);
    chk("t2_en_low_stays_idle", longint'(busy), 0);
    chk("t2_dp2_left", q2.size(), 600 - 2 * BW);
    chk("t2_dp3_left", q3.size(), 600 - 2 * BW);
    q2.delete(); q3.delete(); m2.delete(); m3.delete();
    @(negedge clk);

    // dp3 only: back-to-back packets with a fixed GAP + IDLE between them
    p2 = pop2; d = done_cnt;
    load(1, 2 * BW); sched(2); en = 1'b1;
    wait_done(d + 2, 2000, "t3_two_packets");
    chk("t3_cs_gap", last_cs_gap, 4);
    chk("t3_no_dp2_rd", pop2 - p2, 0);
    wait_idle(50, "t3_idle");

    // FLAGA low for 10 cycles after word 100
    d = done_cnt; max_stall = 0; p2 = pop2;
    load(0, BW); sched(1);
    wait_pop2(p2 + 100, 1000, "t4_reach_word100");
    fx3.FLAGA_i = 1'b0;
    repeat (10) @(negedge clk);
    fx3.FLAGA_i = 1'b1;
    wait_done(d + 1, 1000, "t4_packet_done");
    chk("t4_pause_len", max_stall, 10);
    wait_idle(50, "t4_idle");

    // Short packet: 40 words then empty
    d = done_cnt; pk = pktend_cnt; w0 = wr_cnt;
    load(0, 40); sched(1);
`ifdef USB_WR_SCHED_PKTEND_EN
    wait_done(d + 1, 400, "t5_short_done");
    chk("t5_pktend_count", pktend_cnt - pk, 1);
    chk("t5_stall_len", last_stall, TMO);
    chk("t5_words", wr_cnt - w0, 40);
`else
    repeat (500) @(negedge clk);
    chk("t5_no_pktend", pktend_cnt - pk, 0);
    chk("t5_no_done", done_cnt - d, 0);
    chk("t5_still_busy", longint'(busy), 1);
    chk("t5_words", wr_cnt - w0, 40);
    load(0, BW - 40);
    while (m2.size() > 0) exp_q.push_back({2'd2, m2.pop_front()});
    exp_done.push_back(1 * 4096 + BW);
    wait_done(d + 1, 1000, "t5_complete_done");
`endif
    wait_idle(50, "t5_idle");

    // Asynchronous reset at word 50 of a dp2 packet, then dp2 wins first
    d = done_cnt; p2 = pop2;
    load(0, 300); sched(1);
    wait_pop2(p2 + 50, 1000, "t6_reach_word50");
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_slcs",   longint'(fx3.SLCSn_o), 1);
    chk("t6_async_slwr",   longint'(fx3.SLWRn_o), 1);
    chk("t6_async_pktend", longint'(fx3.PKTENDn_o), 1);
    chk("t6_async_busy",   longint'(busy), 0);
    chk("t6_async_rd",     longint'({dp2_rd, dp3_rd}), 0);
    chk("t6_async_dq",     longint'(fx3.DQ_o), 0);
    q2.delete(); q3.delete(); m2.delete(); m3.delete();
    exp_q.delete(); exp_done.delete();
    m_last = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    load(0, BW); load(1, BW); sched(2);
    wait_done(d + 2, 2000, "t6_two_packets");
    wait_idle(50, "t6_idle");

    chk("exp_words_left", exp_q.size(), 0);
    chk("exp_done_left", exp_done.size(), 0);
    chk("rd_both_events", both_err, 0);
    chk("fifo_underflow", under_err, 0);
`ifdef USB_WR_SCHED_PKTEND_EN
    chk("pktend_total", pktend_cnt, 1);
`else
    chk("pktend_total", pktend_cnt, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
